// File: rtl/wb_invsqrt_initiator_pkg.sv
// Shared types and constants for the Wishbone inverse-square-root initiator.
package wb_invsqrt_initiator_pkg;

    localparam int INT_WIDTH   = 12;
    localparam int FRACT_WIDTH = 4;
    localparam int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH;
    localparam int ADR_WIDTH   = 32;
    localparam int CNT_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        WRITE  = 3'b001,
        GAP    = 3'b010,
        READ   = 3'b011,
        OUTPUT = 3'b100
    } state_t;

    // Everything the initiator drives onto the bus, registered as one bundle
    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [ADR_WIDTH-1:0]  adr;
        logic [DATA_WIDTH-1:0] dat;
    } wb_req_t;

    // Released bus: strobes low, address and data parked at zero
    localparam wb_req_t WB_IDLE = '0;

    function automatic wb_req_t wb_req(input logic                  we,
                                       input logic [ADR_WIDTH-1:0]  adr,
                                       input logic [DATA_WIDTH-1:0] dat);
        wb_req_t r;
        r.cyc = 1'b1;
        r.stb = 1'b1;
        r.we  = we;
        r.adr = adr;
        r.dat = dat;
        return r;
    endfunction

endpackage

// File: rtl/wb_invsqrt_initiator.sv
// Streams one Q12.4 operand at a time to a memory-mapped inverse-sqrt
// accelerator: write operand, wait a fixed gap, read result, hand it on.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | s_ready high, bus released, waiting for an operand
// WRITE  | write strobe to BASE_ADR with the operand, waiting for ack
// GAP    | bus released, counting GAP_CYCLES while the accelerator works
// READ   | read strobe to BASE_ADR+4, waiting for ack
// OUTPUT | m_valid high with result (or timeout flag) until m_ready
module wb_invsqrt_initiator
    import wb_invsqrt_initiator_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h8000_1000,
    parameter int          GAP_CYCLES = 8,
    parameter int          TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] adr_o,
    output logic [15:0] dat_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [15:0] dat_i,
    input  logic        ack_i
);

    // Terminal counts for the shared gap/timeout counter
    localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [31:0]          RESULT_ADR   = BASE_ADR + 32'd4;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    wb_req_t               r_bus;
    logic                  r_s_ready;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_err;
    logic                  r_m_valid;

    // Sequencer: bus requests, gap/timeout counting and result hand-off.
    // A bus cycle times out once TIMEOUT strobed cycles pass without ack;
    // ack is tested first so an ack on the last allowed cycle still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bus     <= WB_IDLE;
            r_s_ready <= 1'b1;
            r_m_data  <= '0;
            r_m_err   <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid && r_s_ready) begin
                        r_s_ready <= 1'b0;
                        r_cnt     <= '0;
                        r_bus     <= wb_req(1'b1, BASE_ADR, s_data);
                        r_state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (ack_i) begin
                        r_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_bus   <= wb_req(1'b0, RESULT_ADR, '0);
                            r_state <= READ;
                        end else begin
                            r_bus   <= WB_IDLE;
                            r_state <= GAP;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt     <= '0;
                        r_bus     <= WB_IDLE;
                        r_m_data  <= '0;
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_state   <= OUTPUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // ack_i is deliberately ignored here: the bus is released
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_bus   <= wb_req(1'b0, RESULT_ADR, '0);
                        r_state <= READ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (ack_i) begin
                        r_cnt     <= '0;
                        r_bus     <= WB_IDLE;
                        r_m_data  <= dat_i;
                        r_m_err   <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_state   <= OUTPUT;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt     <= '0;
                        r_bus     <= WB_IDLE;
                        r_m_data  <= '0;
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_state   <= OUTPUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_bus     <= WB_IDLE;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_data  = r_m_data;
    assign m_err   = r_m_err;
    assign m_valid = r_m_valid;
    assign cyc_o   = r_bus.cyc;
    assign stb_o   = r_bus.stb;
    assign we_o    = r_bus.we;
    assign adr_o   = r_bus.adr;
    assign dat_o   = r_bus.dat;

endmodule
